// File: rtl/header_responder.sv
// Holds an 80-byte block header as 20 big-endian words and serves one word per
// request to the hashing core; the nonce field can be advanced in place.
module header_responder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load_en,
  input  logic [7:0]  i_load_byte,
  input  logic        i_load_rst,
  input  logic        i_nonce_inc,
  input  logic        i_rq,
  input  logic [4:0]  i_addr,
  output logic [31:0] o_data,
  output logic        o_rdy,
  output logic        o_loaded,
  output logic [31:0] o_nonce,
  output logic        o_nonce_wrap
);

  localparam int          NUM_WORDS  = 20;
  localparam logic [6:0]  LAST_BYTE  = 7'd79;
  localparam logic [4:0]  NONCE_WORD = 5'd19;

  typedef enum logic {
    ST_LOADING = 1'b0,
    ST_LOADED  = 1'b1
  } state_t;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Lane 0 is the most significant byte, matching serialization order.
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  lane,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      2'd3:    r[7:0]   = b;
      default: r = w;
    endcase
    return r;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_bp;
  logic [6:0]  w_bp_nxt;
  logic [31:0] r_data;
  logic        r_rdy;
  logic        r_nonce_wrap;
  logic [31:0] w_mem [0:NUM_WORDS-1];
  logic [31:0] w_rd_word;

  logic        w_load_wr;
  logic [4:0]  w_load_word;
  logic [1:0]  w_load_lane;
  logic        w_bp_last;
  logic        w_load_hits_nonce;
  logic [31:0] w_nonce_cur;
  logic [31:0] w_nonce_nxt;
  logic        w_nonce_wr;
  logic        w_nonce_wraps;

  // A load_rst in the same cycle drops the byte entirely.
  assign w_load_wr         = i_load_en & ~i_load_rst;
  assign w_load_word       = r_bp[6:2];
  assign w_load_lane       = r_bp[1:0];
  assign w_bp_last         = (r_bp == LAST_BYTE);
  assign w_load_hits_nonce = w_load_wr & (w_load_word == NONCE_WORD);

  assign w_nonce_cur   = byte_swap(w_mem[NONCE_WORD]);
  assign w_nonce_nxt   = w_nonce_cur + 32'd1;
  assign w_nonce_wr    = i_nonce_inc & ~w_load_hits_nonce;
  assign w_nonce_wraps = w_nonce_wr & (w_nonce_cur == 32'hFFFF_FFFF);

  // Header storage: each word takes either a loaded byte or the incremented nonce.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
    logic [31:0] r_word;
    logic        w_byte_we;
    logic        w_nonce_we;

    assign w_byte_we  = w_load_wr & (w_load_word == 5'(g));
    assign w_nonce_we = w_nonce_wr & (5'(g) == NONCE_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= 32'h0000_0000;
      end else if (w_nonce_we) begin
        r_word <= byte_swap(w_nonce_nxt);
      end else if (w_byte_we) begin
        r_word <= put_byte(r_word, w_load_lane, i_load_byte);
      end else begin
        r_word <= r_word;
      end
    end

    assign w_mem[g] = r_word;
  end

  // Byte pointer next value.
  always_comb begin
    w_bp_nxt = r_bp;
    if (i_load_rst) begin
      w_bp_nxt = 7'd0;
    end else if (i_load_en) begin
      if (w_bp_last) begin
        w_bp_nxt = 7'd0;
      end else begin
        w_bp_nxt = r_bp + 7'd1;
      end
    end else begin
      w_bp_nxt = r_bp;
    end
  end

  // Byte pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bp <= 7'd0;
    end else begin
      r_bp <= w_bp_nxt;
    end
  end

  // Load state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_LOADING;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load state next-state: LOADED once the 80th byte lands, until load_rst.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOADING: begin
        if (i_load_rst) begin
          w_state_nxt = ST_LOADING;
        end else if (i_load_en && w_bp_last) begin
          w_state_nxt = ST_LOADED;
        end else begin
          w_state_nxt = ST_LOADING;
        end
      end
      ST_LOADED: begin
        if (i_load_rst) begin
          w_state_nxt = ST_LOADING;
        end else begin
          w_state_nxt = ST_LOADED;
        end
      end
      default: w_state_nxt = ST_LOADING;
    endcase
  end

  // Load state outputs.
  always_comb begin
    o_loaded = 1'b0;
    case (r_state)
      ST_LOADING: o_loaded = 1'b0;
      ST_LOADED:  o_loaded = 1'b1;
      default:    o_loaded = 1'b0;
    endcase
  end

  // Read mux; addresses past the header return zero.
  always_comb begin
    w_rd_word = 32'h0000_0000;
    case (i_addr)
      5'd0:    w_rd_word = w_mem[0];
      5'd1:    w_rd_word = w_mem[1];
      5'd2:    w_rd_word = w_mem[2];
      5'd3:    w_rd_word = w_mem[3];
      5'd4:    w_rd_word = w_mem[4];
      5'd5:    w_rd_word = w_mem[5];
      5'd6:    w_rd_word = w_mem[6];
      5'd7:    w_rd_word = w_mem[7];
      5'd8:    w_rd_word = w_mem[8];
      5'd9:    w_rd_word = w_mem[9];
      5'd10:   w_rd_word = w_mem[10];
      5'd11:   w_rd_word = w_mem[11];
      5'd12:   w_rd_word = w_mem[12];
      5'd13:   w_rd_word = w_mem[13];
      5'd14:   w_rd_word = w_mem[14];
      5'd15:   w_rd_word = w_mem[15];
      5'd16:   w_rd_word = w_mem[16];
      5'd17:   w_rd_word = w_mem[17];
      5'd18:   w_rd_word = w_mem[18];
      5'd19:   w_rd_word = w_mem[19];
      default: w_rd_word = 32'h0000_0000;
    endcase
  end

  // Registered read port; the mux sees storage before this edge's writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 32'h0000_0000;
      r_rdy  <= 1'b0;
    end else if (i_rq) begin
      r_data <= w_rd_word;
      r_rdy  <= 1'b1;
    end else begin
      r_data <= r_data;
      r_rdy  <= 1'b0;
    end
  end

  // Wrap pulse, aligned with the nonce update it reports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nonce_wrap <= 1'b0;
    end else begin
      r_nonce_wrap <= w_nonce_wraps;
    end
  end

  assign o_data       = r_data;
  assign o_rdy        = r_rdy;
  assign o_nonce_wrap = r_nonce_wrap;
  assign o_nonce      = w_nonce_cur;

endmodule

// File: doc/header_responder.md
# header_responder

Bus responder that stores an 80-byte Bitcoin block header and serves it, one 32-bit word per request, to the double-SHA-256 initiator's read bus (`rq`/`addr` in, `data`/`rdy` out). A host loads the header byte-serially. An internal nonce counter advances the header's nonce field in place, so successive hash attempts need no reload. It sits between the host-facing I/O logic and the sha256d hashing core.

## Interface
- No parameters; header size is fixed at 80 bytes / 20 words.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write `load_byte` at the current byte pointer this cycle.
- `load_byte`  in  8  header byte, in Bitcoin serialization order.
- `load_rst`  in  1  synchronous; byte pointer to 0 and `loaded` to 0.
- `nonce_inc`  in  1  single-cycle pulse; increment the nonce by 1.
- `rq`  in  1  read request from the initiator.
- `addr`  in  5  word address; 0–15 is block 1, 16–19 is block 2 words 0–3.
- `data`  out  32  read word, big-endian byte packing.
- `rdy`  out  1  `data` is valid for the `addr` sampled on the previous edge.
- `loaded`  out  1  all 80 bytes have been written since the last reset or `load_rst`.
- `nonce`  out  32  current nonce as an integer (little-endian decode of bytes 76–79).
- `nonce_wrap`  out  1  one-cycle pulse when the nonce wraps from 0xFFFFFFFF to 0.

## Operation
- **Storage:** 20 × 32-bit words, `mem[0..19]`.
  - Header byte k goes to `mem[k>>2]` bits `[31-8*(k%4) -: 8]`; byte 0 is the MSB of word 0.
- **Load path:**
  - 7-bit byte pointer `bp`, 0..79.
  - On `load_en`: write `load_byte` at `bp`, then `bp` increments.
  - At `bp`=79 with `load_en`: `bp` goes to 0 and `loaded` is set. `loaded` stays set through later writes until `load_rst` or reset.
  - `load_rst` has priority over a `load_en` in the same cycle; the byte is dropped.
- **Nonce:**
  - `nonce` = `{mem[19][7:0], mem[19][15:8], mem[19][23:16], mem[19][31:24]}`.
  - On `nonce_inc`: compute `nonce+1` mod 2^32 and write it back byte-swapped into `mem[19]`.
  - On the 0xFFFFFFFF → 0 transition, pulse `nonce_wrap` for one cycle.
  - Loading bytes 76–79 directly sets the nonce.
- **Write conflict:** if `load_en` writes a byte of word 19 in the same cycle as `nonce_inc`, the load wins and the increment is discarded.
- **Read path (fully registered):**
  - Each cycle `rq`=1: `data <= mem[addr]` (0 for `addr` 20–31) and `rdy <= 1`.
  - Each cycle `rq`=0: `rdy <= 0`; `data` holds its last value.
- **Read/write coherency:** a read samples storage before any same-cycle load or nonce write, so it returns the old value. The new value is visible on the next request cycle.
- **Nonce timing:** the nonce may change while a hash is in progress. Upstream control must pulse `nonce_inc` only between hash runs; this block does not interlock.
- **No FSM beyond the pointer:** the load path has two states, LOADING (`loaded`=0) and LOADED (`loaded`=1), with transitions as above.

## Timing
- **Reset values:** all `mem` = 0, `bp` = 0, `data` = 0, `rdy` = 0, `loaded` = 0, `nonce_wrap` = 0, so `nonce` = 0.
- **Read latency:** one cycle. `rq`/`addr` are sampled at edge N; `data`/`rdy` are valid after edge N.
  - Holding `rq` high with a changing `addr` gives one word per cycle.
  - `rdy` falls one edge after `rq` falls.
- **Load throughput:** one byte per cycle. `loaded` rises the edge the 80th byte is written.
- **Nonce update:** `mem[19]` and `nonce` update the edge after the `nonce_inc` sample. `nonce_wrap` is high for exactly that following cycle.
- **Reset mid-operation:** asynchronous assertion clears everything immediately; a partial header is lost. After release, the first edge behaves as from reset.
- **Outputs:** all outputs are registered except `nonce`, which is a combinational byte-swap of `mem[19]`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-load, then release, then read `addr` 0 and 19.
  - Required: `data`=0x00000000, `rdy`=1 one cycle after `rq`, `loaded`=0, `nonce`=0.
- **Full load and ordering:** load bytes 0x00..0x4F, then stream `addr` 0..19 with `rq` held.
  - Required: `mem[0]`=0x00010203, `mem[19]`=0x4C4D4E4F, one word per cycle.
  - Required: `nonce`=0x4F4E4D4C; `loaded` rises after the 80th byte; `addr` 25 returns 0.
- **Nonce carry and wrap:** set bytes 76–79 = FF FF FF FF, then pulse `nonce_inc`.
  - Required: `mem[19]`=0x00000000, `nonce`=0, `nonce_wrap` high for one cycle.
  - Then pulse again from bytes FF 00 00 00: required `mem[19]`=0x00010000, `nonce`=0x100.
- **Collisions:**
  - `nonce_inc` in the same cycle as `load_en` at byte 77 → the loaded byte wins and the nonce is not incremented.
  - Read of `addr` 19 in the same cycle as `nonce_inc` → old value returned; the next read returns the new value.
- **Handshake:**
  - `rq` pulsed for one cycle → `rdy` high for exactly one cycle.
  - `rq` low → `rdy` low and `data` held.
  - `load_rst` together with `load_en` → `bp`=0, byte dropped, `loaded`=0.
